// File: rtl/logic_op_pkg.sv
// Shared op encoding and golden bitwise-op function for the logic pipe.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package logic_op_pkg;

  // Widest operand the shared function handles; narrower callers zero-extend and slice.
  localparam int max_width_lp = 64;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_XNOR   = 3'd3,
    OP_NAND   = 3'd4,
    OP_NOR    = 3'd5,
    OP_PASS_A = 3'd6,
    OP_NOT_A  = 3'd7
  } op_e;

  // Bitwise result at full width; b is ignored for the two single-operand ops.
  function automatic logic [max_width_lp-1:0] logic_op_f(
    input op_e                     op,
    input logic [max_width_lp-1:0] a,
    input logic [max_width_lp-1:0] b
  );
    logic [max_width_lp-1:0] r;
    r = '0;
    case (op)
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_XNOR:   r = a ~^ b;
      OP_NAND:   r = ~(a & b);
      OP_NOR:    r = ~(a | b);
      OP_PASS_A: r = a;
      OP_NOT_A:  r = ~a;
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/popcount.sv
// Counts set bits of a width_p-bit vector; result sized to hold 0..width_p.
// Latency: purely combinational.
// Backpressure: n/a.
module popcount #(
  parameter  int width_p    = 8,
  localparam int match_w_lp = $clog2(width_p + 1)
) (
  input  logic [width_p-1:0]    in_i,
  output logic [match_w_lp-1:0] count_o
);

  // Linear adder chain; the count width always covers width_p so it never wraps.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < width_p; i++) begin
      count_o = count_o + match_w_lp'(in_i[i]);
    end
  end

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Registered bitwise op on two operands plus equal-bit match count, with consume counter.
// Latency: 1 cycle from accepted input to valid_o; one transaction per cycle sustained.
// Backpressure: ready_o = ~valid_o | ready_i; a stalled result holds and new inputs are ignored.
module bitwise_logic_pipe
  import logic_op_pkg::*;
#(
  parameter  int width_p    = 8,
  localparam int match_w_lp = $clog2(width_p + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [width_p-1:0]    a_i,
  input  logic [width_p-1:0]    b_i,
  input  op_e                   op_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [width_p-1:0]    c_o,
  output logic [match_w_lp-1:0] match_o,
  output logic [15:0]           count_o
);

  typedef struct packed {
    logic [width_p-1:0]    c;
    logic [match_w_lp-1:0] match;
  } result_t;

  logic [max_width_lp-1:0] a_ext;
  logic [max_width_lp-1:0] b_ext;
  logic [max_width_lp-1:0] op_full;
  logic                    unused_op_bits;
  logic [width_p-1:0]      eq_bits;
  logic [match_w_lp-1:0]   match_next;
  result_t                 next_res;
  result_t                 res_q;
  logic                    valid_q;
  logic [15:0]             count_q;
  logic                    accept;
  logic                    consume;

  // The shared op function works at the widest size; operands are zero-extended in
  // and only the low width_p bits of the result are kept.
  assign a_ext = max_width_lp'(a_i);
  assign b_ext = max_width_lp'(b_i);

  // Op result from the shared golden function.
  always_comb begin
    op_full = logic_op_f(op_i, a_ext, b_ext);
  end

  // Bits above width_p are don't-care; fold them into a sink so they are visibly discarded.
  assign unused_op_bits = ^op_full;

  // Match count is independent of op: equal bit positions between a and b.
  assign eq_bits = a_i ~^ b_i;

  popcount #(
    .width_p (width_p)
  ) u_popcount (
    .in_i    (eq_bits),
    .count_o (match_next)
  );

  assign next_res = '{c: op_full[width_p-1:0], match: match_next};

  // Elastic single-entry output stage: ready depends only on state and the consumer.
  assign ready_o = ~valid_q | ready_i;
  assign accept  = valid_i & ready_o;
  assign consume = valid_q & ready_i;

  // Output register: load on accept (covers simultaneous consume), clear valid on a bare consume.
  // Data is left untouched on consume so c_o/match_o keep their last values.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_q <= 1'b0;
      res_q   <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      res_q   <= next_res;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

  // Consumed-result counter, free-running modulo 2^16.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else if (consume) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign valid_o = valid_q;
  assign c_o     = res_q.c;
  assign match_o = res_q.match;
  assign count_o = count_q;

  // An op select that is X/Z while offered would silently pick an arbitrary result.
  op_known_a : assert property (@(posedge clk_i) disable iff (!reset_ni)
    valid_i |-> !$isunknown(op_i));

endmodule

// File: doc/bitwise_logic_pipe.md
Name: bitwise_logic_pipe

Overview:
Parametrised, registered successor to the 2-input XNOR gate. Applies one of eight bitwise operations to two width_p-bit operands. Each accepted result carries a match count: the popcount of a XNOR b, i.e. the number of equal bit positions. Results pass through an elastic ready/valid output stage, so the block can sit between producer and consumer stages in the datapath labs.

Parameters:
width_p, 8, operand and result width in bits; legal range 1..64.
match_w_lp, $clog2(width_p+1), derived localparam; width of the match count. Not overridable.

Ports:
clk_i  input  1  rising-edge clock
reset_ni  input  1  asynchronous active-low reset
valid_i  input  1  operand/op presented
ready_o  output  1  block can accept this cycle
a_i  input  width_p  operand A
b_i  input  width_p  operand B
op_i  input  3  operation select, logic_op_pkg::op_e
valid_o  output  1  result held in output register
ready_i  input  1  consumer accepts result
c_o  output  width_p  registered bitwise result
match_o  output  match_w_lp  registered popcount(a ~^ b)
count_o  output  16  number of results consumed since reset

Behaviour:
- Reset: reset_ni low asserts reset immediately, regardless of clock. While reset is held: valid_o=0, c_o=0, match_o=0, count_o=0. Release is synchronised by the environment.
- Op encoding: 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 PASS_A, 7 NOT_A.
- Op behaviour: all ops are bitwise across width_p. b_i is ignored for ops 6 and 7.
- Match count: match_o is always popcount(a_i ~^ b_i), independent of op_i. It ranges 0..width_p and never wraps. Example: width_p=1 gives a 1-bit match_o equal to a~^b.
- Handshake: ready_o = ~valid_o | ready_i, so the block sustains one transaction per cycle. A handshake occurs when valid_i & ready_o.
- Capture: on the clock edge after a handshake, c_o and match_o load the new result and valid_o=1. Latency is 1 cycle.
- Consume: when valid_o & ready_i and there is no new handshake, valid_o clears on the next edge. c_o and match_o keep their last values.
- Stall: when valid_o & ~ready_i, ready_o=0. c_o and match_o hold stable, and input changes are ignored.
- Simultaneous consume and accept: the output register reloads and valid_o stays 1, with no bubble.
- count_o: increments on each edge where valid_o & ready_i. It wraps from 0xFFFF to 0x0000.
- ready_o is combinational from valid_o and ready_i only. There is no combinational path from any data input to any output.
- Reset mid-operation: any pending result is discarded and count_o clears.
- Assertion (simulation only): op_i must not be X/Z when valid_i=1.

Decomposition:
- Package logic_op_pkg holds the op_e enum (3-bit, values above).
- Package logic_op_pkg also holds the function logic_op_f(op, a, b), used by both DUT and bench as the golden model.
- One sub-module, popcount #(width_p), purely combinational: in_i width_p, count_o match_w_lp.
- Everything else stays in bitwise_logic_pipe: output register, handshake, counter.

Test Plan:
- Exhaustive, width_p=1: all 8 ops × 4 a/b combinations with ready_i=1. Each result appears 1 cycle after accept. Example: op XNOR, a=1, b=0 gives c_o=0, match_o=0.
- width_p=8, op XOR, a=0xA5, b=0x0F, ready_i=1: next cycle valid_o=1, c_o=0xAA, match_o=4. count_o becomes 1 one cycle later.
- Backpressure, width_p=8: result 0x3C held, then ready_i=0 for 3 cycles while new inputs are driven. Required: ready_o=0, c_o stays 0x3C, valid_o stays 1. On ready_i=1 the next input is accepted in the same cycle, with no bubble and no loss.
- Streaming: 256 random back-to-back transactions, ready_i=1. Required: every c_o matches logic_op_f and count_o=256. Repeat with random ready_i; all results still arrive in order with no drops or duplicates.
- Async reset mid-stall: assert reset_ni=0 between clock edges. Required: valid_o, c_o, match_o, count_o go to 0 before the next edge, and ready_o=1 after release.
- Counter wrap: run 65537 consumes. Required: count_o=1, and match_o for a=b=0xFF is 8 (the full-width boundary).
